// File: rtl/lfsr_prbs_gen.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_prbs_gen
//  Purpose  : Parametrised Fibonacci LFSR / PRBS generator. It has a run-time
//             loadable tap mask and seed, and advances STEP bits on each
//             enabled cycle. It recovers from the all-zero state and measures
//             the sequence period in enabled cycles.
//  Ports    : clk        - clock, all logic on rising edge
//             rstn       - asynchronous active-low reset
//             cfg_we     - load cfg_taps into tap register (next cycle onward)
//             cfg_taps   - new tap mask, bit i = term x^(i+1)
//             seed_load  - load seed into state and start register
//             seed       - seed value
//             en         - advance LFSR by STEP bits
//             state      - current LFSR register
//             bits       - feedback bits of last step, first-generated in MSB
//             valid      - bits updated this cycle
//             lockup     - pulse: all-zero state recovered
//             wrap       - pulse: state returned to start value
//             period     - enabled cycles of last completed period
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr_prbs_gen #(
    parameter int                 WIDTH        = 16,
    parameter int                 STEP         = 1,
    parameter logic [WIDTH-1:0]   DEFAULT_TAPS = 16'hB400,
    parameter logic [WIDTH-1:0]   DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int                 CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_we,
    input  logic [WIDTH-1:0]  cfg_taps,
    input  logic              seed_load,
    input  logic [WIDTH-1:0]  seed,
    input  logic              en,
    output logic [WIDTH-1:0]  state,
    output logic [STEP-1:0]   bits,
    output logic              valid,
    output logic              lockup,
    output logic              wrap,
    output logic [CNT_W-1:0]  period
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [WIDTH-1:0] r_taps;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_start;
    logic [CNT_W-1:0] r_cnt;
    logic [STEP-1:0]  r_bits;
    logic             r_valid;
    logic             r_lockup;
    logic             r_wrap;
    logic [CNT_W-1:0] r_period;

    // w_chain[i] is the state after i single shifts within this cycle
    logic [WIDTH-1:0] w_chain [0:STEP];
    logic [STEP-1:0]  w_fb;
    logic [WIDTH-1:0] w_next;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_chain[0] = r_state;

    genvar gi;
    generate
        for (gi = 0; gi < STEP; gi++) begin : g_step
            // First-generated feedback bit lands in the MSB of w_fb
            assign w_fb[STEP-1-gi]  = ^(w_chain[gi] & r_taps);
            assign w_chain[gi+1]    = {w_chain[gi][WIDTH-2:0], w_fb[STEP-1-gi]};
        end
    endgenerate

    assign w_next    = w_chain[STEP];
    // Saturating step counter so a non-maximal or huge sequence cannot wrap the count
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_taps   <= DEFAULT_TAPS;
            r_state  <= DEFAULT_SEED;
            r_start  <= DEFAULT_SEED;
            r_cnt    <= '0;
            r_bits   <= '0;
            r_valid  <= 1'b0;
            r_lockup <= 1'b0;
            r_wrap   <= 1'b0;
            r_period <= '0;
        end else begin
            r_valid  <= 1'b0;
            r_lockup <= 1'b0;
            r_wrap   <= 1'b0;

            // Tap update is independent; a step this cycle still sees the old taps
            if (cfg_we) begin
                r_taps <= cfg_taps;
            end

            if (seed_load) begin
                r_state <= seed;
                r_start <= seed;
                r_cnt   <= '0;
            end else if (en) begin
                if (r_state == '0) begin
                    // All-zero lock-up: restart the sequence from the default seed
                    r_state  <= DEFAULT_SEED;
                    r_start  <= DEFAULT_SEED;
                    r_cnt    <= '0;
                    r_lockup <= 1'b1;
                end else begin
                    r_state <= w_next;
                    r_bits  <= w_fb;
                    r_valid <= 1'b1;
                    if (w_next == r_start) begin
                        r_wrap   <= 1'b1;
                        r_period <= w_cnt_inc;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
            end
        end
    end

    assign state  = r_state;
    assign bits   = r_bits;
    assign valid  = r_valid;
    assign lockup = r_lockup;
    assign wrap   = r_wrap;
    assign period = r_period;

endmodule
`default_nettype wire
